// File: rtl/branch_resolve_pkg.sv
// Shared pipeline definitions: decoded branch ops, EX resolve FSM states and
// predictor 2-bit counter encodings used by the ID-stage predictor.
package branch_resolve_pkg;

   typedef logic [5:0] alu_op_t;

   localparam alu_op_t BEQ = 6'b001011;
   localparam alu_op_t BLT = 6'b001100;
   localparam alu_op_t BGE = 6'b001101;
   localparam alu_op_t JAL = 6'b001110;

   typedef enum logic {
      IDLE  = 1'b0,
      FLUSH = 1'b1
   } br_state_t;

   typedef enum logic [1:0] {
      PRED_SNT = 2'b00,
      PRED_WNT = 2'b01,
      PRED_WT  = 2'b10,
      PRED_ST  = 2'b11
   } pred_state_t;

endpackage

// File: rtl/branch_resolve_if.sv
// EX-stage branch bus: instruction operands in, predictor update, fetch
// redirect, squash and performance counters out.
interface branch_resolve_if
   import branch_resolve_pkg::*;
#(
   parameter int CNT_W = 32
);
   logic             ex_valid;
   logic             stall;
   alu_op_t          alu_op;
   logic [31:0]      reg_data1;
   logic [31:0]      reg_data2;
   logic [31:0]      imm;
   logic [31:0]      ex_pc;
   logic             pred_taken;
   logic             upd_we;
   logic             upd_taken;
   logic             redirect_valid;
   logic [31:0]      redirect_pc;
   logic             flush;
   logic [CNT_W-1:0] br_cnt;
   logic [CNT_W-1:0] mis_cnt;

   modport master (
      output ex_valid, stall, alu_op, reg_data1, reg_data2, imm, ex_pc, pred_taken,
      input  upd_we, upd_taken, redirect_valid, redirect_pc, flush, br_cnt, mis_cnt
   );

   modport slave (
      input  ex_valid, stall, alu_op, reg_data1, reg_data2, imm, ex_pc, pred_taken,
      output upd_we, upd_taken, redirect_valid, redirect_pc, flush, br_cnt, mis_cnt
   );
endinterface

// File: rtl/branch_resolve_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] cnt
);
   logic [W-1:0] cnt_q;

   function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt_q <= '0;
      else if (inc)
         cnt_q <= sat_inc(cnt_q);
   end

   assign cnt = cnt_q;
endmodule

// File: rtl/branch_resolve.sv
// EX-stage branch resolution: compares operands, checks the ID prediction,
// updates the predictor, redirects fetch and squashes IF/ID on a mispredict.
module branch_resolve
   import branch_resolve_pkg::*;
#(
   parameter int CNT_W     = 32,
   parameter int FLUSH_CYC = 2
) (
   input logic             clk,
   input logic             rst,
   branch_resolve_if.slave bus
);
   localparam int              FC_W    = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
   localparam logic [FC_W-1:0] FC_LOAD = FC_W'(FLUSH_CYC - 1);

   br_state_t          state_q, state_d;
   logic [FC_W-1:0]    fcnt_q, fcnt_d;
   logic               is_br_p0, cond_p0, vld_p0, mis_p0;
   logic signed [31:0] rs1_p0, rs2_p0;
   logic [31:0]        tgt_p0, fall_p0;
   logic               upd_we_p1, upd_taken_p1, redir_vld_p1, flush_p1;
   logic [31:0]        redir_pc_p1;
   logic [CNT_W-1:0]   br_cnt_q, mis_cnt_q;

   // Stage p0: combinational resolve of the EX instruction
   assign rs1_p0  = bus.reg_data1;
   assign rs2_p0  = bus.reg_data2;
   assign tgt_p0  = bus.ex_pc + bus.imm;
   assign fall_p0 = bus.ex_pc + 32'd4;

   always_comb begin
      is_br_p0 = 1'b0;
      cond_p0  = 1'b0;
      case (bus.alu_op)
         BEQ: begin is_br_p0 = 1'b1; cond_p0 = (rs1_p0 == rs2_p0); end
         BLT: begin is_br_p0 = 1'b1; cond_p0 = (rs1_p0 <  rs2_p0); end
         BGE: begin is_br_p0 = 1'b1; cond_p0 = (rs1_p0 >= rs2_p0); end
         default: ;
      endcase
   end

   // Wrong-path instructions during FLUSH never resolve
   assign vld_p0 = bus.ex_valid & ~bus.stall & (state_q == IDLE) & is_br_p0;
   assign mis_p0 = vld_p0 & (cond_p0 != bus.pred_taken);

   always_comb begin
      state_d = state_q;
      fcnt_d  = fcnt_q;
      case (state_q)
         IDLE: begin
            if (mis_p0) begin
               state_d = FLUSH;
               fcnt_d  = FC_LOAD;
            end
         end
         FLUSH: begin
            if (fcnt_q == '0)
               state_d = IDLE;
            else
               fcnt_d = fcnt_q - 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   // Stage p1: registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         fcnt_q       <= '0;
         upd_we_p1    <= 1'b0;
         upd_taken_p1 <= 1'b0;
         redir_vld_p1 <= 1'b0;
         redir_pc_p1  <= '0;
         flush_p1     <= 1'b0;
      end else begin
         state_q      <= state_d;
         fcnt_q       <= fcnt_d;
         upd_we_p1    <= vld_p0;
         upd_taken_p1 <= vld_p0 & cond_p0;
         redir_vld_p1 <= mis_p0;
         flush_p1     <= (state_d == FLUSH);
         if (mis_p0)
            redir_pc_p1 <= cond_p0 ? tgt_p0 : fall_p0;
      end
   end

   sat_counter #(.W(CNT_W)) u_br_cnt (
      .clk (clk),
      .rst (rst),
      .inc (vld_p0),
      .cnt (br_cnt_q)
   );

   sat_counter #(.W(CNT_W)) u_mis_cnt (
      .clk (clk),
      .rst (rst),
      .inc (mis_p0),
      .cnt (mis_cnt_q)
   );

   assign bus.upd_we         = upd_we_p1;
   assign bus.upd_taken      = upd_taken_p1;
   assign bus.redirect_valid = redir_vld_p1;
   assign bus.redirect_pc    = redir_pc_p1;
   assign bus.flush          = flush_p1;
   assign bus.br_cnt         = br_cnt_q;
   assign bus.mis_cnt        = mis_cnt_q;
endmodule

// File: tb/tb_branch_resolve.sv
// Scoreboard bench for branch_resolve: a cycle-level model predicts every
// output after each clock edge; a negedge monitor pops and compares.
module tb_branch_resolve;
   import branch_resolve_pkg::*;

   localparam int TB_CNT_W = 5;
   localparam int TB_FLUSH = 2;
   localparam int CMAX     = (1 << TB_CNT_W) - 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   branch_resolve_if #(.CNT_W(TB_CNT_W)) bus();

   branch_resolve #(.CNT_W(TB_CNT_W), .FLUSH_CYC(TB_FLUSH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic        upd_we;
      logic        upd_taken;
      logic        rv;
      logic [31:0] rpc;
      logic        flush;
      int          br;
      int          mis;
   } exp_t;

   exp_t sbq[$];
   exp_t mon_e;
   int   checks   = 0;
   int   failures = 0;

   // Reference model: cycles of flush still owed, last redirect, event totals
   int          m_flush_left = 0;
   logic [31:0] m_rpc        = '0;
   int          m_br         = 0;
   int          m_mis        = 0;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=0x%08h required=0x%08h t=%0t", name, act, req, $time);
      end
   endfunction

   function automatic void model_step();
      exp_t e;
      logic taken;
      logic is_br;
      e.upd_we = 0; e.upd_taken = 0; e.rv = 0;
      if (rst) begin
         m_flush_left = 0; m_rpc = '0; m_br = 0; m_mis = 0;
      end else if (m_flush_left > 0) begin
         m_flush_left--;
      end else begin
         is_br = (bus.alu_op == BEQ) || (bus.alu_op == BLT) || (bus.alu_op == BGE);
         if (bus.ex_valid && !bus.stall && is_br) begin
            if (bus.alu_op == BEQ)      taken = (bus.reg_data1 == bus.reg_data2);
            else if (bus.alu_op == BLT) taken = ($signed(bus.reg_data1) <  $signed(bus.reg_data2));
            else                        taken = ($signed(bus.reg_data1) >= $signed(bus.reg_data2));
            if (m_br < CMAX) m_br++;
            e.upd_we = 1; e.upd_taken = taken;
            if (taken != bus.pred_taken) begin
               if (m_mis < CMAX) m_mis++;
               e.rv = 1;
               m_rpc = taken ? bus.ex_pc + bus.imm : bus.ex_pc + 32'd4;
               m_flush_left = TB_FLUSH;
            end
         end
      end
      e.rpc = m_rpc; e.flush = (m_flush_left > 0); e.br = m_br; e.mis = m_mis;
      sbq.push_back(e);
   endfunction

   always @(negedge clk) begin
      if (sbq.size() > 0) begin
         mon_e = sbq.pop_front();
         chk("sb_upd_we",    32'(bus.upd_we),         32'(mon_e.upd_we));
         chk("sb_upd_taken", 32'(bus.upd_taken),      32'(mon_e.upd_taken));
         chk("sb_redir_vld", 32'(bus.redirect_valid), 32'(mon_e.rv));
         chk("sb_redir_pc",  bus.redirect_pc,         mon_e.rpc);
         chk("sb_flush",     32'(bus.flush),          32'(mon_e.flush));
         chk("sb_br_cnt",    32'(bus.br_cnt),         32'(mon_e.br));
         chk("sb_mis_cnt",   32'(bus.mis_cnt),        32'(mon_e.mis));
      end
   end

   task automatic cycle(input logic v, input logic st, input logic [5:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] im, input logic [31:0] pc, input logic pt);
      bus.ex_valid = v; bus.stall = st; bus.alu_op = op;
      bus.reg_data1 = a; bus.reg_data2 = b; bus.imm = im; bus.ex_pc = pc; bus.pred_taken = pt;
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic idle();
      cycle(1'b0, 1'b0, 6'd0, '0, '0, '0, '0, 1'b0);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_upd_we"}, 32'(bus.upd_we),         32'd0);
      chk({tag, "_redir"},  32'(bus.redirect_valid), 32'd0);
      chk({tag, "_rpc"},    bus.redirect_pc,         32'd0);
      chk({tag, "_flush"},  32'(bus.flush),          32'd0);
      chk({tag, "_br"},     32'(bus.br_cnt),         32'd0);
      chk({tag, "_mis"},    32'(bus.mis_cnt),        32'd0);
   endtask

   initial begin
      logic [5:0]  ops  [5];
      logic [31:0] vals [6];
      ops  = '{BEQ, BLT, BGE, JAL, 6'h00};
      vals = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'd5, 32'h7FFF_FFFF, 32'h8000_0000};
      bus.ex_valid = 0; bus.stall = 0; bus.alu_op = '0; bus.reg_data1 = '0;
      bus.reg_data2 = '0; bus.imm = '0; bus.ex_pc = '0; bus.pred_taken = 0;
      repeat (2) @(posedge clk);
      #1;
      chk_all_zero("reset");
      rst = 0;

      // Predicted-correct BEQ
      cycle(1, 0, BEQ, 32'd5, 32'd5, 32'h20, 32'h100, 1);
      chk("beq_upd_we", 32'(bus.upd_we), 32'd1);
      chk("beq_upd_taken", 32'(bus.upd_taken), 32'd1);
      chk("beq_no_redir", 32'(bus.redirect_valid), 32'd0);
      chk("beq_br_cnt", 32'(bus.br_cnt), 32'd1);
      idle();

      // Signed BLT mispredict, taken
      cycle(1, 0, BLT, 32'hFFFF_FFFF, 32'd1, 32'h40, 32'h200, 0);
      chk("blt_redir_vld", 32'(bus.redirect_valid), 32'd1);
      chk("blt_redir_pc", bus.redirect_pc, 32'h240);
      chk("blt_flush1", 32'(bus.flush), 32'd1);
      chk("blt_mis_cnt", 32'(bus.mis_cnt), 32'd1);
      idle();
      chk("blt_flush2", 32'(bus.flush), 32'd1);
      chk("blt_redir_pulse", 32'(bus.redirect_valid), 32'd0);
      idle();
      chk("blt_flush_end", 32'(bus.flush), 32'd0);
      chk("blt_pc_hold", bus.redirect_pc, 32'h240);

      // BGE not taken mispredict, then a wrong-path branch during flush
      cycle(1, 0, BGE, 32'd1, 32'd2, 32'h80, 32'h300, 1);
      chk("bge_redir_pc", bus.redirect_pc, 32'h304);
      cycle(1, 0, BEQ, 32'd5, 32'd5, 32'h10, 32'h304, 0);
      chk("squash_upd_we", 32'(bus.upd_we), 32'd0);
      chk("squash_br_cnt", 32'(bus.br_cnt), 32'd3);
      idle(); idle();

      // Stall held 3 cycles then released, then JAL
      for (int i = 0; i < 3; i++) begin
         cycle(1, 1, BEQ, 32'd5, 32'd5, 32'h8, 32'h400, 1);
         chk("stall_no_upd", 32'(bus.upd_we), 32'd0);
      end
      cycle(1, 0, BEQ, 32'd5, 32'd5, 32'h8, 32'h400, 1);
      chk("stall_release_upd", 32'(bus.upd_we), 32'd1);
      chk("stall_br_cnt", 32'(bus.br_cnt), 32'd4);
      cycle(1, 0, JAL, 32'd0, 32'd0, 32'h100, 32'h500, 1);
      chk("jal_no_upd", 32'(bus.upd_we), 32'd0);
      chk("jal_no_redir", 32'(bus.redirect_valid), 32'd0);
      chk("jal_br_cnt", 32'(bus.br_cnt), 32'd4);

      // Wrap-around taken target
      cycle(1, 0, BEQ, 32'd7, 32'd7, 32'h20, 32'hFFFF_FFF0, 0);
      chk("wrap_redir_pc", bus.redirect_pc, 32'h0000_0010);
      idle(); idle();

      // Back-to-back correctly predicted branches
      cycle(1, 0, BEQ, 32'd1, 32'd2, 32'h20, 32'h600, 0);
      cycle(1, 0, BLT, 32'd1, 32'd2, 32'h20, 32'h604, 1);
      chk("b2b_second_upd", 32'(bus.upd_we), 32'd1);
      chk("b2b_br_cnt", 32'(bus.br_cnt), 32'd7);

      // Reset asserted in the first flush cycle
      cycle(1, 0, BLT, 32'hFFFF_FFFF, 32'd1, 32'h40, 32'h700, 0);
      chk("pre_rst_flush", 32'(bus.flush), 32'd1);
      bus.ex_valid = 0;
      @(negedge clk);
      #1 rst = 1;
      #1 chk_all_zero("midrst");
      @(posedge clk);
      model_step();
      #1 rst = 0;
      cycle(1, 0, BEQ, 32'd3, 32'd3, 32'h20, 32'h800, 1);
      chk("post_rst_upd", 32'(bus.upd_we), 32'd1);
      chk("post_rst_br", 32'(bus.br_cnt), 32'd1);

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         cycle($urandom_range(3, 0) != 0, $urandom_range(4, 0) == 0,
               ops[$urandom_range(4, 0)],
               ($urandom_range(1, 0) != 0) ? vals[$urandom_range(5, 0)] : $urandom(),
               vals[$urandom_range(5, 0)],
               $urandom(), $urandom(), $urandom_range(1, 0) != 0);
      end
      idle(); idle();

      // Drive both counters into saturation
      for (int i = 0; i < CMAX + 4; i++) begin
         cycle(1, 0, BEQ, 32'd9, 32'd9, 32'h40, 32'h900, 0);
         idle(); idle();
      end
      chk("sat_br_pre", 32'(bus.br_cnt), 32'(CMAX));
      chk("sat_mis_pre", 32'(bus.mis_cnt), 32'(CMAX));
      cycle(1, 0, BGE, 32'd1, 32'd2, 32'h40, 32'hA00, 1);
      chk("sat_mis_hold", 32'(bus.mis_cnt), 32'(CMAX));
      chk("sat_redir_pc", bus.redirect_pc, 32'hA04);
      idle(); idle();

      bus.ex_valid = 0;
      repeat (3) @(negedge clk);
      chk("sb_drained", 32'(sbq.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/branch_resolve.md
# branch_resolve

EX-stage branch resolution unit, the counterpart of the ID-stage branch predictor. For each conditional branch it compares the two operands, checks the actual outcome against the prediction made in ID, and returns the outcome to the predictor's history and pattern tables. On a misprediction it redirects fetch and squashes the wrong-path instructions. It also keeps branch and mispredict counters for performance measurement.

## Interface
Parameters:
- CNT_W, 32, width of the performance counters
- FLUSH_CYC, 2, number of cycles flush stays asserted after a mispredict (IF and ID slots)

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-high reset
- ex_valid  in  1  the EX slot holds a live instruction
- stall  in  1  pipeline stall; holds the EX instruction unresolved
- alu_op  in  6  decoded op: BEQ=6'b001011, BLT=6'b001100, BGE=6'b001101, JAL=6'b001110
- reg_data1  in  32  rs1 operand, after forwarding
- reg_data2  in  32  rs2 operand, after forwarding
- imm  in  32  branch offset, sign-extended
- ex_pc  in  32  PC of the EX instruction
- pred_taken  in  1  ID prediction, carried down the pipeline with the instruction
- upd_we  out  1  predictor update strobe (predictor `we`)
- upd_taken  out  1  actual outcome (predictor `jmp_from_ex`)
- redirect_valid  out  1  single-cycle fetch redirect
- redirect_pc  out  32  corrected fetch address
- flush  out  1  squash the IF and ID slots
- br_cnt  out  CNT_W  count of resolved conditional branches
- mis_cnt  out  CNT_W  count of mispredicts

## Operation
- Resolve condition: `ex_valid & ~stall & state==IDLE & alu_op in {BEQ,BLT,BGE}`.
- Branch conditions:
  - BEQ: reg_data1 == reg_data2.
  - BLT: signed reg_data1 < reg_data2.
  - BGE: signed reg_data1 >= reg_data2.
- Targets:
  - taken target = ex_pc + imm.
  - fall-through = ex_pc + 4.
  - All arithmetic is 32-bit modulo; wrap-around is silently ignored.
- Mispredict = actual != pred_taken.
  - Actual taken: redirect_pc = taken target.
  - Actual not taken: redirect_pc = fall-through.
- JAL is always predicted taken in ID, so it is never a mispredict and generates no update. Other ops generate nothing.
- FSM states: IDLE, FLUSH.
  - IDLE → FLUSH on a resolve with mispredict; a down-counter loads FLUSH_CYC-1.
  - FLUSH: flush=1. The counter decrements each cycle; at 0, return to IDLE.
  - In FLUSH, the EX instruction is wrong-path: ex_valid is ignored, with no update and no counting.
  - stall does not hold the FSM.
- Counters:
  - br_cnt increments on every resolve.
  - mis_cnt increments on every mispredict.
  - Both saturate at all-ones.
- Reset: all outputs, both counters and the FSM (IDLE) are 0. Reset mid-flush aborts the flush immediately.

## Timing
- Resolution is combinational in cycle N. All outputs are registered and appear in cycle N+1.
- upd_we, upd_taken:
  - upd_we is a one-cycle pulse at N+1 for every resolved conditional branch.
  - upd_taken is valid while upd_we=1 and 0 otherwise.
- redirect_valid, redirect_pc:
  - redirect_valid is a one-cycle pulse at N+1.
  - redirect_pc holds its last value otherwise; 0 after reset.
- flush is high for cycles N+1 .. N+FLUSH_CYC.
- A stalled branch (stall=1) stays unresolved; it resolves once, in the first cycle with stall=0.
- Back-to-back branches:
  - Two branches in N and N+1 with no mispredict in N give two upd_we pulses, at N+1 and N+2.
  - If N mispredicts, the branch arriving in N+1 is squashed.
- Counter values are visible the cycle after the event.

## Structure
- Shared pipeline package holds:
  - the alu_op localparams (BEQ/BLT/BGE/JAL), shared with ID/EX/predictor
  - the FSM state enum
  - the predictor 2-bit state encodings
- One natural sub-module: `sat_counter` (width-parameterised increment-with-saturation), instantiated twice.
- Compare/target logic stays inline.

## Test plan
- **Predicted-correct BEQ**
  - Stimulus: BEQ, r1=r2=5, pred_taken=1, ex_pc=0x100, imm=0x20.
  - Response at N+1: upd_we=1, upd_taken=1; no redirect, no flush; br_cnt=1, mis_cnt=0.
- **Signed BLT mispredict**
  - Stimulus: BLT, r1=0xFFFFFFFF (−1), r2=1, pred_taken=0, ex_pc=0x200, imm=0x40.
  - Response: redirect_valid pulse with redirect_pc=0x240; flush high 2 cycles; mis_cnt=1.
- **BGE not-taken mispredict**
  - Stimulus: BGE, r1=1, r2=2, pred_taken=1, ex_pc=0x300.
  - Response: redirect_pc=0x304; a branch presented during flush produces no upd_we and no count.
- **Stall and JAL**
  - Stimulus: BEQ held under stall for 3 cycles, then released; separately a JAL.
  - Response: exactly one upd_we, one cycle after release; JAL produces no upd_we, no redirect, no count change.
- **Reset and saturation**
  - Stimulus: assert rst in the first flush cycle; separately preload mis_cnt to 0xFFFFFFFF and drive a mispredict.
  - Response: after rst, flush=0, state IDLE, all outputs 0; mis_cnt stays 0xFFFFFFFF.
- **Wrap-around target**
  - Stimulus: ex_pc=0xFFFFFFF0, imm=0x20, taken, predicted not taken.
  - Response: redirect_pc=0x00000010.
